mem_bist_initiator: RTL and testbench
=====================================

Name: mem_bist_initiator

Overview:
- Initiator-side engine for the single-port memory's op/addr/data_in/data_out interface.
- On a start request it writes a deterministic pattern to every address, reads every address back, and compares the returned data against the expected pattern.
- It reports pass/fail, the mismatch count and the first failing address.
- It sits between system control and the memory and drives the memory's request signals in place of a testbench.

Parameters:
- DATA_WIDTH, 8, width of the memory data word.
- ADDR_WIDTH, 4, width of the memory address; the sweep covers 0 to 2**ADDR_WIDTH-1.
- RD_LATENCY, 1, cycles from the op=0 request edge until data_out is valid (1..4).
- SEED, 8'hA5, DATA_WIDTH-wide pattern constant.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level; sampled only in IDLE.
- busy  output  1  high while a test is in progress.
- done  output  1  one-cycle pulse when a test completes.
- pass  output  1  high when the last completed test had 0 mismatches.
- err_count  output  ADDR_WIDTH+1  number of mismatches in the last or current test.
- fail_addr  output  ADDR_WIDTH  address of the first mismatch; 0 if none.
- mem_op  output  1  1 = write, 0 = read; drives memory op.
- mem_addr  output  ADDR_WIDTH  drives memory addr.
- mem_wdata  output  DATA_WIDTH  drives memory data_in.
- mem_rdata  input  DATA_WIDTH  from memory data_out.

Behaviour:
- Reset values: busy=0, done=0, pass=0, err_count=0, fail_addr=0, mem_op=0, mem_addr=0, mem_wdata=0, state=IDLE, read pipeline valid bits cleared.
- Pattern: pat(a) = SEED XOR a, with a zero-extended or truncated to DATA_WIDTH.
- All memory-side outputs are registered.

State machine:
- IDLE: mem_op=0, busy=0.
  - start=1 at an edge -> WRITE.
  - At the same edge: addr counter=0, err_count=0, fail_addr=0, pass=0, busy=1.
- WRITE: each cycle drives mem_op=1, mem_addr=cnt, mem_wdata=pat(cnt).
  - cnt increments each cycle.
  - After the cycle driving addr 2**ADDR_WIDTH-1 -> READ, with cnt reset to 0.
  - Duration is exactly 2**ADDR_WIDTH cycles.
- READ: each cycle drives mem_op=0, mem_addr=cnt, mem_wdata=0.
  - {valid=1, addr=cnt} is pushed into a RD_LATENCY-deep shift pipeline.
  - After the last address -> DRAIN.
  - Duration is 2**ADDR_WIDTH cycles; reads are issued back-to-back.
- DRAIN: mem_op=0, nothing is pushed; lasts RD_LATENCY cycles, then -> DONE.
- DONE: done=1 and busy=0 for one cycle; pass=(err_count==0); -> IDLE.
- Busy window: busy is high for exactly 2*2**ADDR_WIDTH + RD_LATENCY cycles. With the defaults that is 33 cycles; done asserts on the 34th.

Compare:
- In any cycle where the pipeline output is valid, mem_rdata is compared to pat(pipe_addr).
- On mismatch, err_count increments. If it was 0 before this mismatch, fail_addr captures pipe_addr.
- err_count cannot overflow: it has ADDR_WIDTH+1 bits for at most 2**ADDR_WIDTH errors.
- The final compare lands in the last DRAIN cycle, so pass in DONE includes it.

Result hold and start handling:
- pass, err_count and fail_addr hold after DONE until the next accepted start.
- start outside IDLE is ignored. A start held high through DONE re-launches a test on the IDLE edge immediately after DONE.

Reset:
- Reset mid-operation returns to IDLE on that edge with all reset values; no done pulse is produced.
- Memory contents are not restored.
- Reset has priority over start when both are high at the same edge.

Decomposition:
- Package mem_bist_pkg:
  - state enum {IDLE, WRITE, READ, DRAIN, DONE};
  - localparams OP_READ=0, OP_WRITE=1;
  - function pat().
- One sub-module, mem_bist_rdpipe: a RD_LATENCY-deep valid/address delay line with synchronous reset.

Test Plan:
- Fault-free run: defaults with a fault-free behavioural memory; reset 2 cycles, then start=1 for 1 cycle -> busy high 33 cycles, done pulse on the 34th, pass=1, err_count=0, fail_addr=0, and mem_wdata at addr 3 = 8'hA6.
- Stuck-at fault: memory model with data_out bit 0 stuck at 0 -> addresses whose pat bit 0 is 1 (even addrs, since A5 is odd) fail -> err_count=8, fail_addr=0, pass=0.
- Single-word corruption: corrupt only addr 5 on read (flip bit 7) -> err_count=1, fail_addr=5, pass=0.
- Reset and start interaction: assert reset at cycle 10 of WRITE -> next edge busy=0, mem_op=0, err_count=0, no done. Then start pulses during READ -> ignored, and the cycle count is still 33.
- RD_LATENCY=3 with a 3-stage memory model -> busy 35 cycles, pass=1. Misaligning the model to latency 2 -> pass=0, err_count=16.
- Back-to-back: start held high -> second test begins the cycle after done; results from the first test are cleared at relaunch.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory BIST initiator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, memory op encodings, and the pattern generator.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // The pattern is computed at a fixed wide width. Callers zero-extend the
  // address and seed into it and truncate the result to their data width, so
  // the pattern stays SEED ^ addr for any data width up to PAT_W.
  localparam int PAT_W = 64;

  function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] seed,
                                           input logic [PAT_W-1:0] addr);
    return seed ^ addr;
  endfunction

endpackage

// File: rtl/mem_bist_rdpipe.sv
// Read-tracking delay line: carries {valid, addr} of each issued read.
// Latency: DEPTH cycles from push to out.
// Backpressure: none; shifts every cycle.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   push, push_addr      read issued this cycle and its address
//   out_vld, out_addr    read whose data is on the memory data bus this cycle
module mem_bist_rdpipe #(
  parameter int DEPTH = 1,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  output logic          out_vld,
  output logic [AW-1:0] out_addr
);

  logic [DEPTH-1:0] vld_q;
  logic [AW-1:0]    addr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= push;
      addr_q[0] <= push_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_addr = addr_q[DEPTH-1];

endmodule

// File: rtl/mem_bist_initiator.sv
// Memory BIST initiator: writes SEED^addr everywhere, reads back, counts mismatches.
// Latency: 2*2**ADDR_WIDTH + RD_LATENCY busy cycles, then a one-cycle done.
// Backpressure: none; start is only sampled in IDLE, ignored otherwise.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   start                          level request, taken only in IDLE
//   busy, done                     test in progress / one-cycle completion pulse
//   pass, err_count, fail_addr     result of the last (or current) test
//   mem_op, mem_addr, mem_wdata    registered request to the memory (1 = write)
//   mem_rdata                      read data from the memory
module mem_bist_initiator
  import mem_bist_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] SEED       = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic                  mem_op,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [2:0]            DRAIN_END = 3'(RD_LATENCY - 1);

  state_t state, state_n;

  // mem_addr doubles as the sweep counter: it always holds the address being
  // presented to the memory in the current WRITE/READ cycle.
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [2:0]            drain_cnt, drain_n;

  logic                  op_n, busy_n, done_n, pass_n;
  logic [ADDR_WIDTH-1:0] addr_n, fail_n;
  logic [DATA_WIDTH-1:0] wdata_n;
  logic [ADDR_WIDTH:0]   err_n;

  logic                  pipe_vld;
  logic [ADDR_WIDTH-1:0] pipe_addr;
  logic [DATA_WIDTH-1:0] pat_zero, pat_inc, pat_pipe;
  logic                  mismatch;

  assign addr_inc = mem_addr + ADDR_WIDTH'(1);
  assign pat_zero = DATA_WIDTH'(pat(PAT_W'(SEED), '0));
  assign pat_inc  = DATA_WIDTH'(pat(PAT_W'(SEED), PAT_W'(addr_inc)));
  assign pat_pipe = DATA_WIDTH'(pat(PAT_W'(SEED), PAT_W'(pipe_addr)));

  // A read is tracked from the edge that issues it until its data appears.
  mem_bist_rdpipe #(
    .DEPTH (RD_LATENCY),
    .AW    (ADDR_WIDTH)
  ) u_rdpipe (
    .clk       (clk),
    .reset     (reset),
    .push      (state == READ),
    .push_addr (mem_addr),
    .out_vld   (pipe_vld),
    .out_addr  (pipe_addr)
  );

  assign mismatch = pipe_vld && (mem_rdata != pat_pipe);

  always_comb begin
    state_n = state;
    op_n    = OP_READ;
    addr_n  = '0;
    wdata_n = '0;
    drain_n = drain_cnt;
    err_n   = err_count;
    fail_n  = fail_addr;
    pass_n  = pass;

    // Compare runs whenever returning data is valid, independent of state,
    // so the last read is still scored while in DRAIN.
    if (mismatch) begin
      err_n = err_count + 1'b1;
      if (err_count == '0) begin
        fail_n = pipe_addr;
      end
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_n = WRITE;
          op_n    = OP_WRITE;
          wdata_n = pat_zero;
          err_n   = '0;
          fail_n  = '0;
          pass_n  = 1'b0;
        end
      end
      WRITE: begin
        if (mem_addr == LAST_ADDR) begin
          state_n = READ;
        end else begin
          op_n    = OP_WRITE;
          addr_n  = addr_inc;
          wdata_n = pat_inc;
        end
      end
      READ: begin
        if (mem_addr == LAST_ADDR) begin
          state_n = DRAIN;
          drain_n = '0;
        end else begin
          addr_n = addr_inc;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_END) begin
          state_n = DONE;
          // Uses err_n so the final compare in this cycle is included.
          pass_n  = (err_n == '0);
        end else begin
          drain_n = drain_cnt + 3'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n == WRITE) || (state_n == READ) || (state_n == DRAIN);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      mem_op    <= OP_READ;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      err_count <= err_n;
      fail_addr <= fail_n;
      mem_op    <= op_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
    end
  end

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Bench for mem_bist_initiator: two instances (read latency 1 and 3) with
// behavioural memories and fault injection; results scored from a queue.
module tb_mem_bist_initiator;

  localparam int DW = 8;
  localparam int AW = 4;

  typedef struct {
    logic pass;
    int   err;
    int   fail;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_a, start_b;

  logic          busy_a, done_a, pass_a, op_a;
  logic [AW:0]   err_a;
  logic [AW-1:0] fail_a, addr_a;
  logic [DW-1:0] wdata_a, rdata_a;

  logic          busy_b, done_b, pass_b, op_b;
  logic [AW:0]   err_b;
  logic [AW-1:0] fail_b, addr_b;
  logic [DW-1:0] wdata_b, rdata_b;

  int n_chk  = 0;
  int n_pass = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  int fault_a = 0;  // 0 none, 1 bit0 stuck at 0, 2 flip bit7 at addr 5
  int lat_b   = 3;  // model read latency for instance b

  mem_bist_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .SEED(8'hA5)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .fail_addr(fail_a), .mem_op(op_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_rdata(rdata_a)
  );

  mem_bist_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(3), .SEED(8'hA5)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .fail_addr(fail_b), .mem_op(op_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_pat(input logic [AW-1:0] a);
    return 8'hA5 ^ {4'h0, a};
  endfunction

  function automatic logic [DW-1:0] inject(input logic [DW-1:0] d, input logic [AW-1:0] a,
                                           input int mode);
    case (mode)
      1:       return d & 8'hFE;
      2:       return (a == 4'd5) ? (d ^ 8'h80) : d;
      default: return d;
    endcase
  endfunction

  // Memory a: one-cycle read latency, optional fault on read.
  logic [DW-1:0] mem_a [16];
  logic [DW-1:0] rd_a;
  always @(posedge clk) begin
    if (op_a) mem_a[addr_a] <= wdata_a;
    rd_a <= inject(mem_a[addr_a], addr_a, fault_a);
  end
  assign rdata_a = rd_a;

  // Memory b: three-stage read pipe, tap selectable to fake a latency of 2.
  logic [DW-1:0] mem_b [16];
  logic [DW-1:0] rb [3];
  always @(posedge clk) begin
    if (op_b) mem_b[addr_b] <= wdata_b;
    rb[0] <= mem_b[addr_b];
    rb[1] <= rb[0];
    rb[2] <= rb[1];
  end
  assign rdata_b = (lat_b == 2) ? rb[1] : rb[2];

  // Monitor a: write data, busy window length, scored results on done.
  initial begin
    int   cnt;
    exp_t e;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0;
      end else begin
        if (busy_a) cnt++;
        if (op_a) chk("a_wdata", wdata_a, model_pat(addr_a));
        if (op_a && addr_a == 4'd3) chk("a_wdata_addr3", wdata_a, 8'hA6);
        if (done_a) begin
          chk("a_done_expected", q_a.size() > 0, 1);
          if (q_a.size() > 0) begin
            e = q_a.pop_front();
            chk("a_pass", pass_a, e.pass);
            chk("a_err_count", err_a, e.err);
            chk("a_fail_addr", fail_a, e.fail);
            chk("a_busy_cycles", cnt, e.cyc);
          end
          cnt = 0;
        end
      end
    end
  end

  // Monitor b.
  initial begin
    int   cnt;
    exp_t e;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0;
      end else begin
        if (busy_b) cnt++;
        if (op_b) chk("b_wdata", wdata_b, model_pat(addr_b));
        if (done_b) begin
          chk("b_done_expected", q_b.size() > 0, 1);
          if (q_b.size() > 0) begin
            e = q_b.pop_front();
            chk("b_pass", pass_b, e.pass);
            chk("b_err_count", err_b, e.err);
            chk("b_fail_addr", fail_b, e.fail);
            chk("b_busy_cycles", cnt, e.cyc);
          end
          cnt = 0;
        end
      end
    end
  end

  task automatic pulse_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic pulse_b();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  // Returns at the negedge where done is seen, or flags a timeout.
  task automatic wait_done(input bit which_b, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (which_b ? done_b : done_a) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_fail", fail_a, 0);
    chk("rst_op", op_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_wdata", wdata_a, 0);
    reset = 1'b0;
    @(negedge clk);

    // Fault-free run.
    q_a.push_back('{1'b1, 0, 0, 33});
    pulse_a();
    chk("t1_busy_after_start", busy_a, 1);
    wait_done(1'b0, "t1");

    // Stuck-at-0 on data bit 0: every even address fails, first is 0.
    fault_a = 1;
    @(negedge clk);
    q_a.push_back('{1'b0, 8, 0, 33});
    pulse_a();
    wait_done(1'b0, "stuck");

    // Single corrupted word at address 5; results hold after done.
    fault_a = 2;
    @(negedge clk);
    q_a.push_back('{1'b0, 1, 5, 33});
    pulse_a();
    wait_done(1'b0, "corrupt");
    repeat (3) @(negedge clk);
    chk("hold_pass", pass_a, 0);
    chk("hold_err", err_a, 1);
    chk("hold_fail", fail_a, 5);

    // Reset during WRITE: immediate return to idle, results cleared, no done.
    fault_a = 0;
    pulse_a();
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_op", op_a, 0);
    chk("midrst_err", err_a, 0);
    chk("midrst_done", done_a, 0);
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a) n_done++;
    end
    chk("midrst_no_done", n_done, 0);

    // Start pulses during READ are ignored; window still 33 cycles.
    q_a.push_back('{1'b1, 0, 0, 33});
    pulse_a();
    repeat (18) @(negedge clk);
    start_a = 1'b1;
    repeat (3) @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0, "ignore_start");
    repeat (2) @(negedge clk);
    chk("ignore_start_no_relaunch", busy_a, 0);

    // Read latency 3, matched model, then model one cycle early.
    q_b.push_back('{1'b1, 0, 0, 35});
    pulse_b();
    wait_done(1'b1, "lat3");
    lat_b = 2;
    @(negedge clk);
    q_b.push_back('{1'b0, 16, 0, 35});
    pulse_b();
    wait_done(1'b1, "lat3_misalign");

    // Back-to-back with start held: first run fails, second is clean.
    fault_a = 2;
    q_a.push_back('{1'b0, 1, 5, 33});
    q_a.push_back('{1'b1, 0, 0, 33});
    start_a = 1'b1;
    wait_done(1'b0, "b2b_first");
    fault_a = 0;
    @(negedge clk);
    chk("b2b_idle_busy", busy_a, 0);
    chk("b2b_idle_err_held", err_a, 1);
    @(negedge clk);
    chk("b2b_relaunch_busy", busy_a, 1);
    chk("b2b_relaunch_op", op_a, 1);
    chk("b2b_cleared_err", err_a, 0);
    chk("b2b_cleared_fail", fail_a, 0);
    chk("b2b_cleared_pass", pass_a, 0);
    start_a = 1'b0;
    wait_done(1'b0, "b2b_second");

    repeat (3) @(negedge clk);
    chk("scoreboard_a_empty", q_a.size(), 0);
    chk("scoreboard_b_empty", q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
